ni_local: RTL and testbench



---
 rtl/ni_local_if.sv | 74 +++++++
 rtl/ni_local.sv | 159 +++++++++++++++
 tb/tb_ni_local.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ni_local_if.sv
// Core-side and router-L-side signal bundle for the ni_local network interface.
// Optional stats counters (tx_cnt/rx_cnt) exist only when NI_STATS_EN is defined.
interface ni_local_if #(
    parameter int DATASIZE = 40
);
    logic                core_req_valid;
    logic                core_req_ready;
    logic [3:0]          core_req_dst;
    logic [21:0]         core_req_data;
    logic [1:0]          core_req_type;
    logic [DATASIZE-1:0] L_data_in;
    logic                L_valid_in;
    logic                router_full;
    logic [DATASIZE-1:0] L_data_out;
    logic                L_valid_out;
    logic                core_rx_valid;
    logic [3:0]          core_rx_src;
    logic [21:0]         core_rx_data;
    logic [1:0]          core_rx_type;
    logic [7:0]          core_rx_latency;
    logic [7:0]          misroute_cnt;
`ifdef NI_STATS_EN
    logic [15:0]         tx_cnt;
    logic [15:0]         rx_cnt;
`endif

    modport slave (
        input  core_req_valid,
        output core_req_ready,
        input  core_req_dst,
        input  core_req_data,
        input  core_req_type,
        output L_data_in,
        output L_valid_in,
        input  router_full,
        input  L_data_out,
        input  L_valid_out,
        output core_rx_valid,
        output core_rx_src,
        output core_rx_data,
        output core_rx_type,
        output core_rx_latency,
        output misroute_cnt
`ifdef NI_STATS_EN
        ,
        output tx_cnt,
        output rx_cnt
`endif
    );

    modport master (
        output core_req_valid,
        input  core_req_ready,
        output core_req_dst,
        output core_req_data,
        output core_req_type,
        input  L_data_in,
        input  L_valid_in,
        output router_full,
        output L_data_out,
        output L_valid_out,
        input  core_rx_valid,
        input  core_rx_src,
        input  core_rx_data,
        input  core_rx_type,
        input  core_rx_latency,
        input  misroute_cnt
`ifdef NI_STATS_EN
        ,
        input  tx_cnt,
        input  rx_cnt
`endif
    );
endinterface

// File: rtl/ni_local.sv
// Network interface: core inject queue + output register to router L port, eject with latency.
// Define NI_STATS_EN to add tx_cnt/rx_cnt handshake and delivery counters.
module ni_local #(
    parameter int         DATASIZE = 40,
    parameter logic [3:0] NODE_ID  = 4'd2,
    parameter int         DEPTH    = 4
) (
    input logic       clk,
    input logic       rst,
    ni_local_if.slave ni
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C1   = (AW+1)'(1);
    localparam logic [AW-1:0] P1   = AW'(1);

    typedef enum logic {OR_EMPTY, OR_LOADED} or_state_e;

    logic [7:0]          ts_q;
    logic [DATASIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         cnt_q, cnt_d;
    or_state_e           state_q, state_d;
    logic [DATASIZE-1:0] or_q, or_d;
    logic                ready, accept, hs, or_free;
    logic                bypass, push, pop;
    logic [DATASIZE-1:0] flit_new;

    assign ready    = cnt_q < FULL;
    assign accept   = ni.core_req_valid && ready;
    assign hs       = (state_q == OR_LOADED) && !ni.router_full;
    assign or_free  = (state_q == OR_EMPTY) || hs;
    assign pop      = or_free && (cnt_q != '0);
    assign bypass   = accept && (cnt_q == '0) && or_free;
    assign push     = accept && !bypass;
    assign flit_new = {NODE_ID, ni.core_req_dst, ts_q,
                       ni.core_req_data, ni.core_req_type};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= 8'd0;
        else     ts_q <= ts_q + 8'd1;
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= flit_new;
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + C1;
            2'b01:   cnt_d = cnt_q - C1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + P1;
            if (pop)  rptr_q <= rptr_q + P1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OR_EMPTY;
            or_q    <= '0;
        end else begin
            state_q <= state_d;
            or_q    <= or_d;
        end
    end

    // Queue head has priority over bypass; bypass only fires on an empty queue.
    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        if (or_free) begin
            unique case (1'b1)
                pop: begin
                    state_d = OR_LOADED;
                    or_d    = mem_q[rptr_q];
                end
                bypass: begin
                    state_d = OR_LOADED;
                    or_d    = flit_new;
                end
                default: state_d = OR_EMPTY;
            endcase
        end
    end

    always_comb begin
        ni.L_valid_in     = (state_q == OR_LOADED);
        ni.L_data_in      = or_q;
        ni.core_req_ready = ready;
    end

    logic       rx_valid_q;
    logic [3:0] rx_src_q;
    logic [21:0] rx_data_q;
    logic [1:0] rx_type_q;
    logic [7:0] rx_lat_q;
    logic [7:0] mis_q;
    logic       ej_hit;

    assign ej_hit = ni.L_valid_out && (ni.L_data_out[35:32] == NODE_ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            rx_src_q   <= '0;
            rx_data_q  <= '0;
            rx_type_q  <= '0;
            rx_lat_q   <= '0;
            mis_q      <= '0;
        end else begin
            rx_valid_q <= ej_hit;
            if (ej_hit) begin
                rx_src_q  <= ni.L_data_out[39:36];
                rx_data_q <= ni.L_data_out[23:2];
                rx_type_q <= ni.L_data_out[1:0];
                rx_lat_q  <= ts_q - ni.L_data_out[31:24];
            end else if (ni.L_valid_out && mis_q != 8'hFF) begin
                mis_q <= mis_q + 8'd1;
            end
        end
    end

    assign ni.core_rx_valid   = rx_valid_q;
    assign ni.core_rx_src     = rx_src_q;
    assign ni.core_rx_data    = rx_data_q;
    assign ni.core_rx_type    = rx_type_q;
    assign ni.core_rx_latency = rx_lat_q;
    assign ni.misroute_cnt    = mis_q;

`ifdef NI_STATS_EN
    logic [15:0] tx_cnt_q, rx_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (hs)     tx_cnt_q <= tx_cnt_q + 16'd1;
            if (ej_hit) rx_cnt_q <= rx_cnt_q + 16'd1;
        end
    end

    assign ni.tx_cnt = tx_cnt_q;
    assign ni.rx_cnt = rx_cnt_q;
`endif
endmodule

// File: tb/tb_ni_local.sv
// Directed bench for ni_local with inject/eject scoreboards.
// Define NI_STATS_EN to also check the stats counters.
module tb_ni_local;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ni_local_if #(.DATASIZE(40)) ni ();

    ni_local #(
        .DATASIZE(40),
        .NODE_ID (4'd2),
        .DEPTH   (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ni (ni)
    );

    int          checks = 0;
    int          errors = 0;
    logic [39:0] txq[$];
    logic [35:0] rxq[$];
    logic [7:0]  tb_ts;
    int          tb_tx, tb_rx;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples at negedge, then advances through the next rising edge (+1).
    task automatic cyc();
        logic [39:0] e;
        logic [35:0] r;
        @(negedge clk);
        if (!rst) begin
            if (ni.L_valid_in && !ni.router_full) begin
                if (txq.size() == 0) begin
                    chk("tx_spurious", 64'(ni.L_valid_in), 64'd0);
                end else begin
                    e = txq.pop_front();
                    chk("tx_flit", 64'(ni.L_data_in), 64'(e));
                    tb_tx++;
                end
            end
            if (ni.core_rx_valid) begin
                if (rxq.size() == 0) begin
                    chk("rx_spurious", 64'(ni.core_rx_valid), 64'd0);
                end else begin
                    r = rxq.pop_front();
                    chk("rx_flit", 64'({ni.core_rx_src, ni.core_rx_data,
                        ni.core_rx_type, ni.core_rx_latency}), 64'(r));
                    tb_rx++;
                end
            end
            if (ni.core_req_valid && ni.core_req_ready)
                txq.push_back({4'd2, ni.core_req_dst, tb_ts,
                               ni.core_req_data, ni.core_req_type});
            if (ni.L_valid_out && ni.L_data_out[35:32] == 4'd2)
                rxq.push_back({ni.L_data_out[39:36], ni.L_data_out[23:2],
                               ni.L_data_out[1:0],
                               8'(tb_ts - ni.L_data_out[31:24])});
        end
        @(posedge clk);
        if (!rst) tb_ts++;
        #1;
    endtask

    task automatic wait_ts(input logic [7:0] t);
        int n = 0;
        while (tb_ts != t && n < 300) begin
            cyc();
            n++;
        end
        chk("wait_ts", 64'(tb_ts), 64'(t));
    endtask

    initial begin
        int acc;
        int n;
        logic [39:0] hold;

        rst               = 1'b1;
        tb_ts             = 8'd0;
        tb_tx             = 0;
        tb_rx             = 0;
        ni.core_req_valid = 1'b0;
        ni.core_req_dst   = '0;
        ni.core_req_data  = '0;
        ni.core_req_type  = '0;
        ni.router_full    = 1'b0;
        ni.L_data_out     = '0;
        ni.L_valid_out    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_in", 64'(ni.L_valid_in), 64'd0);
        chk("rst_data_in", 64'(ni.L_data_in), 64'd0);
        chk("rst_ready", 64'(ni.core_req_ready), 64'd1);
        chk("rst_rx_valid", 64'(ni.core_rx_valid), 64'd0);
        chk("rst_rx_lat", 64'(ni.core_rx_latency), 64'd0);
        chk("rst_misroute", 64'(ni.misroute_cnt), 64'd0);
        rst = 1'b0;

        // single inject after 5 idle edges
        repeat (5) cyc();
        ni.core_req_valid = 1'b1;
        ni.core_req_dst   = 4'd5;
        ni.core_req_data  = 22'h12345;
        ni.core_req_type  = 2'b01;
        cyc();
        ni.core_req_valid = 1'b0;
        chk("single_valid", 64'(ni.L_valid_in), 64'd1);
        chk("single_data", 64'(ni.L_data_in),
            64'({4'd2, 4'd5, 8'd5, 22'h12345, 2'b01}));
        cyc();
        chk("single_one_cycle", 64'(ni.L_valid_in), 64'd0);

        // backpressure: 1 in OR + 4 queued
        ni.router_full    = 1'b1;
        ni.core_req_valid = 1'b1;
        acc = 0;
        n   = 0;
        while (acc < 5 && n < 20) begin
            ni.core_req_dst  = 4'(n + 1);
            ni.core_req_data = 22'(n * 1000 + 7);
            ni.core_req_type = 2'(n);
            if (ni.core_req_ready) acc++;
            cyc();
            n++;
        end
        ni.core_req_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_ready_low", 64'(ni.core_req_ready), 64'd0);
        hold = txq[0];
        repeat (2) cyc();
        chk("bp_hold_data", 64'(ni.L_data_in), 64'(hold));
        chk("bp_hold_valid", 64'(ni.L_valid_in), 64'd1);
        ni.router_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_drain_valid", 64'(ni.L_valid_in), 64'd1);
            cyc();
        end
        chk("bp_drained", 64'(ni.L_valid_in), 64'd0);
        chk("bp_txq_empty", 64'(txq.size()), 64'd0);
        chk("bp_ready_back", 64'(ni.core_req_ready), 64'd1);

        // sustained one flit per cycle
        ni.core_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ni.core_req_dst  = 4'(i);
            ni.core_req_data = 22'($urandom);
            ni.core_req_type = 2'(i);
            cyc();
            chk("sus_valid", 64'(ni.L_valid_in), 64'd1);
            chk("sus_ready", 64'(ni.core_req_ready), 64'd1);
        end
        ni.core_req_valid = 1'b0;
        cyc();
        chk("sus_end", 64'(ni.L_valid_in), 64'd0);

        // random valid / backpressure mix
        for (int i = 0; i < 60; i++) begin
            ni.core_req_valid = 1'($urandom_range(0, 1));
            ni.router_full    = 1'($urandom_range(0, 1));
            ni.core_req_dst   = 4'($urandom);
            ni.core_req_data  = 22'($urandom);
            ni.core_req_type  = 2'($urandom);
            cyc();
        end
        ni.core_req_valid = 1'b0;
        ni.router_full    = 1'b0;
        n = 0;
        while (ni.L_valid_in && n < 10) begin
            cyc();
            n++;
        end
        chk("rand_drained", 64'(ni.L_valid_in), 64'd0);
        chk("rand_txq_empty", 64'(txq.size()), 64'd0);

        // eject delivery
        wait_ts(8'd20);
        ni.L_valid_out = 1'b1;
        ni.L_data_out  = {4'd7, 4'd2, 8'd12, 22'h2AAAA, 2'b10};
        cyc();
        ni.L_valid_out = 1'b0;
        chk("ej_valid", 64'(ni.core_rx_valid), 64'd1);
        chk("ej_src", 64'(ni.core_rx_src), 64'd7);
        chk("ej_lat", 64'(ni.core_rx_latency), 64'd8);
        chk("ej_data", 64'(ni.core_rx_data), 64'h2AAAA);
        chk("ej_type", 64'(ni.core_rx_type), 64'd2);
        cyc();
        chk("ej_pulse", 64'(ni.core_rx_valid), 64'd0);

        // latency wrap
        wait_ts(8'd3);
        ni.L_valid_out = 1'b1;
        ni.L_data_out  = {4'd4, 4'd2, 8'd250, 22'h00001, 2'b11};
        cyc();
        ni.L_valid_out = 1'b0;
        chk("wrap_valid", 64'(ni.core_rx_valid), 64'd1);
        chk("wrap_lat", 64'(ni.core_rx_latency), 64'd9);
        cyc();

        // back-to-back deliveries
        for (int i = 0; i < 10; i++) begin
            ni.L_valid_out = 1'b1;
            ni.L_data_out  = {4'($urandom), 4'd2, 8'($urandom),
                              22'($urandom), 2'($urandom)};
            cyc();
        end
        ni.L_valid_out = 1'b0;
        cyc();
        chk("b2b_rxq_empty", 64'(rxq.size()), 64'd0);
        chk("mis_zero", 64'(ni.misroute_cnt), 64'd0);

        // misroute saturation
        ni.L_valid_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ni.L_data_out = {4'd1, 4'd9, 8'($urandom), 22'($urandom), 2'b00};
            cyc();
            if (i == 0) chk("mis_one", 64'(ni.misroute_cnt), 64'd1);
        end
        ni.L_valid_out = 1'b0;
        cyc();
        chk("mis_sat", 64'(ni.misroute_cnt), 64'd255);
        chk("mis_no_rx", 64'(ni.core_rx_valid), 64'd0);

        // reset mid-flight with 3 flits held
        ni.router_full    = 1'b1;
        ni.core_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ni.core_req_data = 22'(i + 100);
            cyc();
        end
        ni.core_req_valid = 1'b0;
        chk("rmf_loaded", 64'(ni.L_valid_in), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rmf_valid_drop", 64'(ni.L_valid_in), 64'd0);
        chk("rmf_ready", 64'(ni.core_req_ready), 64'd1);
        chk("rmf_mis_clr", 64'(ni.misroute_cnt), 64'd0);
        txq.delete();
        rxq.delete();
        tb_ts = 8'd0;
        tb_tx = 0;
        tb_rx = 0;
        cyc();
        rst            = 1'b0;
        ni.router_full = 1'b0;
        repeat (6) cyc();
        chk("rmf_no_stale", 64'(ni.L_valid_in), 64'd0);

        // traffic after reset
        ni.core_req_valid = 1'b1;
        ni.core_req_dst   = 4'd3;
        ni.core_req_data  = 22'h3C3C3;
        ni.core_req_type  = 2'b10;
        cyc();
        ni.core_req_valid = 1'b0;
        ni.L_valid_out    = 1'b1;
        ni.L_data_out     = {4'd6, 4'd2, 8'd0, 22'h11111, 2'b01};
        cyc();
        ni.L_valid_out = 1'b0;
        repeat (3) cyc();
        chk("end_txq_empty", 64'(txq.size()), 64'd0);
        chk("end_rxq_empty", 64'(rxq.size()), 64'd0);
`ifdef NI_STATS_EN
        chk("stats_tx", 64'(ni.tx_cnt), 64'(16'(tb_tx)));
        chk("stats_rx", 64'(ni.rx_cnt), 64'(16'(tb_rx)));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
